// File: rtl/axi_mux.sv
// Packet-level 4:1 AXI4-Stream mux with round-robin grant held until TLAST.
// Optional master-side 2-entry skid buffer: define AXI_MUX_OUTREG_EN.
module axi_mux #(
  parameter int         C_AXIS_DATA_WIDTH = 64,
  parameter logic [3:0] C_ACTIVE_MASK     = 4'b1111
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA0,
  input  logic                         S_AXIS_TVALID0,
  input  logic                         S_AXIS_TLAST0,
  output logic                         S_AXIS_TREADY0,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA1,
  input  logic                         S_AXIS_TVALID1,
  input  logic                         S_AXIS_TLAST1,
  output logic                         S_AXIS_TREADY1,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA2,
  input  logic                         S_AXIS_TVALID2,
  input  logic                         S_AXIS_TLAST2,
  output logic                         S_AXIS_TREADY2,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA3,
  input  logic                         S_AXIS_TVALID3,
  input  logic                         S_AXIS_TLAST3,
  output logic                         S_AXIS_TREADY3,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TVALID,
  output logic                         M_AXIS_TLAST,
  input  logic                         M_AXIS_TREADY,
  output logic [1:0]                   src,
  output logic                         busy
);

  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    ST0  = 4'b0001,
    ST1  = 4'b0010,
    ST2  = 4'b0100,
    ST3  = 4'b1000
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [1:0]                     r_last;
  logic [1:0]                     w_last_nxt;

  logic [C_AXIS_DATA_WIDTH-1:0]   w_tdata [4];
  logic [3:0]                     w_tvalid;
  logic [3:0]                     w_tlast;
  logic [3:0]                     w_req;
  logic [2:0]                     w_pick;
  logic                           w_active;
  logic [1:0]                     w_sel;
  logic                           w_in_rdy;
  logic                           w_in_vld;
  logic                           w_hs_last;
  logic [3:0]                     w_rdy;

  // Returns {found, index}: first requester after the last grant, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!pick[2] && req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_tdata[0] = S_AXIS_TDATA0;
  assign w_tdata[1] = S_AXIS_TDATA1;
  assign w_tdata[2] = S_AXIS_TDATA2;
  assign w_tdata[3] = S_AXIS_TDATA3;
  assign w_tvalid   = {S_AXIS_TVALID3, S_AXIS_TVALID2, S_AXIS_TVALID1, S_AXIS_TVALID0};
  assign w_tlast    = {S_AXIS_TLAST3, S_AXIS_TLAST2, S_AXIS_TLAST1, S_AXIS_TLAST0};
  assign w_req      = w_tvalid & C_ACTIVE_MASK;
  assign w_pick     = rr_pick(w_req, r_last);

  // Selected input; idle and illegal encodings select input 0 with nothing active.
  always_comb begin
    w_active = 1'b0;
    w_sel    = 2'd0;
    case (r_state)
      ST0:     begin w_active = 1'b1; w_sel = 2'd0; end
      ST1:     begin w_active = 1'b1; w_sel = 2'd1; end
      ST2:     begin w_active = 1'b1; w_sel = 2'd2; end
      ST3:     begin w_active = 1'b1; w_sel = 2'd3; end
      default: begin w_active = 1'b0; w_sel = 2'd0; end
    endcase
  end

  assign w_in_vld  = w_active & w_tvalid[w_sel];
  assign w_hs_last = w_in_vld & w_in_rdy & w_tlast[w_sel];
  assign w_rdy     = w_active ? (((4'b0001 << w_sel) & {4{w_in_rdy}}) & C_ACTIVE_MASK) : 4'b0000;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = state_t'(4'b0001 << w_pick[1:0]);
          w_last_nxt  = w_pick[1:0];
        end
      end
      ST0, ST1, ST2, ST3: begin
        if (w_hs_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign S_AXIS_TREADY0 = w_rdy[0];
  assign S_AXIS_TREADY1 = w_rdy[1];
  assign S_AXIS_TREADY2 = w_rdy[2];
  assign S_AXIS_TREADY3 = w_rdy[3];
  assign src            = w_sel;
  assign busy           = (r_state != IDLE);

`ifdef AXI_MUX_OUTREG_EN
  logic [1:0]                     r_cnt;
  logic                           r_wptr;
  logic                           r_rptr;
  logic [C_AXIS_DATA_WIDTH-1:0]   r_bdata [2];
  logic                           r_blast [2];
  logic                           w_push;
  logic                           w_pop;

  // Upstream ready depends only on buffer occupancy, never on M_AXIS_TREADY.
  assign w_in_rdy = (r_cnt != 2'd2);
  assign w_push   = w_in_vld & w_in_rdy;
  assign w_pop    = (r_cnt != 2'd0) & M_AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bdata[r_wptr] <= w_tdata[w_sel];
      r_blast[r_wptr] <= w_tlast[w_sel];
    end
  end

  assign M_AXIS_TVALID = (r_cnt != 2'd0);
  assign M_AXIS_TDATA  = r_bdata[r_rptr];
  assign M_AXIS_TLAST  = r_blast[r_rptr];
`else
  assign w_in_rdy      = M_AXIS_TREADY;
  assign M_AXIS_TVALID = w_in_vld;
  assign M_AXIS_TDATA  = w_tdata[w_sel];
  assign M_AXIS_TLAST  = w_tlast[w_sel];
`endif

endmodule

// File: tb/tb_axi_mux.sv
// Bench for axi_mux: vector table, directed packet sequences, random scoreboard
// run, and a second instance with a partial active mask.
module tb_axi_mux;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       mrdy;
    logic       busy;
    logic [1:0] src;
    logic       mvld;
    logic [3:0] rdy;
    logic       mlst;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_data [4];
  logic [3:0]   s_vld = 4'b0;
  logic [3:0]   s_lst = 4'b0;
  logic [3:0]   s_rdy;
  logic [W-1:0] m_data;
  logic         m_vld, m_lst;
  logic         m_rdy = 1'b1;
  logic [1:0]   src;
  logic         busy;

  logic [W-1:0] k_data [4];
  logic [3:0]   k_rdy;
  logic [W-1:0] k_mdata;
  logic         k_mvld, k_mlst, k_busy;
  logic [1:0]   k_src;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t sq [4][$];
  beat_t rq [4][$];
  int    log_cyc [$];
  int    log_tag [$];
  int    hs_cnt [4];
  logic [3:0] hs_in = 4'b0;
  int    gap_pct = 0;
  bit    rdy_rand = 0;
  bit    eng_en = 0;
  bit    sb_en = 0;
  int    pkts_out = 0;
  bit    in_pkt = 0;
  int    cur_tag = 0;

  int k_viol_rdy = 0, k_viol_src = 0, k_alt_viol = 0, k_cnt0 = 0, k_cnt2 = 0;
  bit k_have_prev = 0;
  int k_prev = 0;

  vec_t tv [13];

  always #5 clk = ~clk;

  axi_mux #(.C_AXIS_DATA_WIDTH(W), .C_ACTIVE_MASK(4'b1111)) u_dut (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA0(s_data[0]), .S_AXIS_TVALID0(s_vld[0]), .S_AXIS_TLAST0(s_lst[0]), .S_AXIS_TREADY0(s_rdy[0]),
    .S_AXIS_TDATA1(s_data[1]), .S_AXIS_TVALID1(s_vld[1]), .S_AXIS_TLAST1(s_lst[1]), .S_AXIS_TREADY1(s_rdy[1]),
    .S_AXIS_TDATA2(s_data[2]), .S_AXIS_TVALID2(s_vld[2]), .S_AXIS_TLAST2(s_lst[2]), .S_AXIS_TREADY2(s_rdy[2]),
    .S_AXIS_TDATA3(s_data[3]), .S_AXIS_TVALID3(s_vld[3]), .S_AXIS_TLAST3(s_lst[3]), .S_AXIS_TREADY3(s_rdy[3]),
    .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_vld), .M_AXIS_TLAST(m_lst), .M_AXIS_TREADY(m_rdy),
    .src(src), .busy(busy)
  );

  // Masked instance: every input always offers single-beat packets.
  axi_mux #(.C_AXIS_DATA_WIDTH(W), .C_ACTIVE_MASK(4'b0101)) u_dut_mask (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA0(k_data[0]), .S_AXIS_TVALID0(1'b1), .S_AXIS_TLAST0(1'b1), .S_AXIS_TREADY0(k_rdy[0]),
    .S_AXIS_TDATA1(k_data[1]), .S_AXIS_TVALID1(1'b1), .S_AXIS_TLAST1(1'b1), .S_AXIS_TREADY1(k_rdy[1]),
    .S_AXIS_TDATA2(k_data[2]), .S_AXIS_TVALID2(1'b1), .S_AXIS_TLAST2(1'b1), .S_AXIS_TREADY2(k_rdy[2]),
    .S_AXIS_TDATA3(k_data[3]), .S_AXIS_TVALID3(1'b1), .S_AXIS_TLAST3(1'b1), .S_AXIS_TREADY3(k_rdy[3]),
    .M_AXIS_TDATA(k_mdata), .M_AXIS_TVALID(k_mvld), .M_AXIS_TLAST(k_mlst), .M_AXIS_TREADY(1'b1),
    .src(k_src), .busy(k_busy)
  );

  assign k_data[0] = {2'd0, 62'h0};
  assign k_data[1] = {2'd1, 62'h0};
  assign k_data[2] = {2'd2, 62'h0};
  assign k_data[3] = {2'd3, 62'h0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_pkt(input int n, input int len, input int id);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.d = {2'(n), 14'h0, 16'(id), 16'(b), 16'($urandom)};
      bt.l = (b == len - 1);
      sq[n].push_back(bt);
      rq[n].push_back(bt);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sq[n].delete();
      rq[n].delete();
      hs_cnt[n] = 0;
    end
    s_vld = 4'b0;
    log_cyc.delete();
    log_tag.delete();
    pkts_out = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source engine: presents queued beats, holds them until accepted, inserts gaps.
  initial forever begin
    @(posedge clk); #1;
    if (eng_en) begin
      for (int n = 0; n < 4; n++) begin
        if (hs_in[n] && sq[n].size() > 0) void'(sq[n].pop_front());
        if (sq[n].size() == 0) begin
          s_vld[n] = 1'b0; s_lst[n] = 1'b0; s_data[n] = '0;
        end else if (s_vld[n] && !hs_in[n]) begin
          s_vld[n] = 1'b1;
        end else if ($urandom_range(99) >= gap_pct) begin
          s_vld[n] = 1'b1; s_data[n] = sq[n][0].d; s_lst[n] = sq[n][0].l;
        end else begin
          s_vld[n] = 1'b0;
        end
      end
      m_rdy = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  initial forever begin
    int    tag, enc;
    beat_t e;
    @(negedge clk);
    hs_in = s_vld & s_rdy;
    for (int n = 0; n < 4; n++) if (hs_in[n]) hs_cnt[n]++;
    if (rst) in_pkt = 0;
    if (s_rdy != 4'b0) begin
      enc = 0;
      for (int n = 3; n >= 0; n--) if (s_rdy[n]) enc = n;
      chk("grant_src", {busy, src, s_rdy}, {1'b1, 2'(enc), 4'(4'b0001 << enc)});
    end
    if (m_vld && m_rdy) begin
      tag = int'(m_data[W-1:W-2]);
      log_cyc.push_back(cyc);
      log_tag.push_back(tag);
      if (sb_en) begin
        if (in_pkt) chk("no_interleave", tag, cur_tag);
        chk("ref_nonempty", rq[tag].size() != 0, 1'b1);
        if (rq[tag].size() != 0) begin
          e = rq[tag].pop_front();
          chk("beat", {m_lst, m_data}, {e.l, e.d});
        end
        in_pkt  = !m_lst;
        cur_tag = tag;
        if (m_lst) pkts_out++;
      end
    end
    if (rst) k_have_prev = 0;
    if (k_rdy[1] || k_rdy[3]) k_viol_rdy++;
    if (k_busy && (k_src == 2'd1 || k_src == 2'd3)) k_viol_src++;
    if (k_mvld && !rst) begin
      tag = int'(k_mdata[W-1:W-2]);
      if (tag == 1 || tag == 3) k_viol_src++;
      if (tag == 0) k_cnt0++;
      if (tag == 2) k_cnt2++;
      if (k_have_prev && tag == k_prev) k_alt_viol++;
      k_prev = tag;
      k_have_prev = 1;
    end
  end

  initial begin
    // vld, lst, mrdy -> busy, src, mvld, rdy, mlst
    tv[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tv[1]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tv[2]  = '{4'b0110, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0};
    tv[3]  = '{4'b0110, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b1};
    tv[4]  = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1};
    tv[5]  = '{4'b0111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tv[6]  = '{4'b0011, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0};
    tv[7]  = '{4'b0111, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1};
    tv[8]  = '{4'b1011, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tv[9]  = '{4'b1011, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
    tv[10] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tv[11] = '{4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
    tv[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    for (int n = 0; n < 4; n++) begin
      s_data[n] = '0;
      hs_cnt[n] = 0;
    end

    // Reset with all inputs idle.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", {m_vld, busy, src, s_rdy}, 8'h00);
    end

    // Vector table, inputs driven directly.
    do_reset();
    for (int n = 0; n < 4; n++) s_data[n] = 64'hA0 + 64'(n);
    for (int i = 0; i < 13; i++) begin
      s_vld = tv[i].vld; s_lst = tv[i].lst; m_rdy = tv[i].mrdy;
      @(negedge clk);
      chk("tv_ctl", {busy, src, m_vld, s_rdy}, {tv[i].busy, tv[i].src, tv[i].mvld, tv[i].rdy});
      if (tv[i].mvld) chk("tv_data", {m_lst, m_data}, {tv[i].mlst, 64'hA0 + 64'(tv[i].src)});
      @(posedge clk); #2;
    end
    s_vld = 4'b0; s_lst = 4'b0; m_rdy = 1'b1;

    // All four inputs offer a 4-beat packet at once.
    do_reset();
    sb_en = 1; eng_en = 1; gap_pct = 0; rdy_rand = 0;
    for (int n = 0; n < 4; n++) load_pkt(n, 4, 100 + n);
    for (int i = 0; i < 200 && log_tag.size() < 16; i++) @(posedge clk);
    chk("rr_beats", log_tag.size(), 16);
    if (log_tag.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("rr_order", log_tag[i], i / 4);
        if (i > 0) chk("rr_spacing", log_cyc[i] - log_cyc[i-1], (i % 4 == 0) ? 2 : 1);
      end
    end

    // Input 1 becomes valid mid-way through an 8-beat packet on input 2.
    do_reset();
    load_pkt(2, 8, 200);
    for (int i = 0; i < 100 && hs_cnt[2] < 3; i++) @(posedge clk);
    chk("hold_beat3", hs_cnt[2], 3);
    load_pkt(1, 3, 201);
    for (int i = 0; i < 200 && log_tag.size() < 11; i++) @(posedge clk);
    chk("hold_beats", log_tag.size(), 11);
    if (log_tag.size() >= 11) begin
      for (int i = 0; i < 11; i++) chk("hold_order", log_tag[i], (i < 8) ? 2 : 1);
      chk("hold_bubble", log_cyc[8] - log_cyc[7], 2);
    end

    // Reset at beat 2 of a 5-beat packet.
    do_reset();
    sb_en = 0;
    load_pkt(0, 5, 300);
    for (int i = 0; i < 100 && hs_cnt[0] < 2; i++) begin
      @(posedge clk); #2;
    end
    chk("rst_at_beat2", hs_cnt[0], 2);
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    sq[0].delete();
    rq[0].delete();
    @(posedge clk); #2;
    chk("rst_mid_pkt", {busy, src, m_vld, s_rdy}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after", {busy, m_vld, s_rdy}, 6'h00);

    // Random traffic: 1000 packets, TVALID gaps and 50% downstream ready.
    do_reset();
    sb_en = 1; gap_pct = 25; rdy_rand = 1;
    for (int p = 0; p < 250; p++)
      for (int n = 0; n < 4; n++) load_pkt(n, int'($urandom_range(1, 6)), p);
    for (int i = 0; i < 60000 && pkts_out < 1000; i++) @(posedge clk);
    chk("rand_pkts", pkts_out, 1000);
    for (int n = 0; n < 4; n++) chk("rand_drained", rq[n].size(), 0);
    eng_en = 0; rdy_rand = 0; m_rdy = 1'b1; s_vld = 4'b0;

    // Masked instance observed over the whole run.
    chk("mask_rdy13", k_viol_rdy, 0);
    chk("mask_src13", k_viol_src, 0);
    chk("mask_alternate", k_alt_viol, 0);
    chk("mask_grant0", k_cnt0 > 10, 1'b1);
    chk("mask_grant2", k_cnt2 > 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
